// File: rtl/fht_frame_loader.sv
// Fills one frame of signed ADC samples into BANKS RAM banks (bank index bit-reversed)
// and hands the frame to an FHT core through a start pulse and a ready handshake.
module fht_frame_loader #(
  parameter int D_BIT = 16,
  parameter int A_BIT = 8,
  parameter int BANKS = 4,
  parameter int GAP   = 2
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iMODE,
  input  logic               iARM,
  input  logic               iVALID,
  input  logic [D_BIT-2:0]   iDATA,
  input  logic               iFHT_RDY,
  input  logic               iCLR_OVF,
  output logic               oREADY,
  output logic [D_BIT-1:0]   oDATA,
  output logic [A_BIT-1:0]   oADDR_WR,
  output logic [BANKS-1:0]   oWE,
  output logic               oSTART,
  output logic               oBUSY,
  output logic               oOVF,
  output logic [7:0]         oFRAME_CNT
);

  localparam int B_BIT = $clog2(BANKS);
  localparam int N_BIT = A_BIT + B_BIT;
  localparam logic [N_BIT-1:0] N_LAST   = {N_BIT{1'b1}};
  localparam logic [3:0]       GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_SETTLE  = 3'd2,
    S_START   = 3'd3,
    S_WAIT_LO = 3'd4,
    S_WAIT_HI = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [N_BIT-1:0]   n_q, n_d;
  logic [3:0]         gap_q, gap_d;
  logic [D_BIT-1:0]   data_q, data_d;
  logic [A_BIT-1:0]   addr_q, addr_d;
  logic [BANKS-1:0]   we_q, we_d;
  logic               start_q, start_d;
  logic               ovf_q, ovf_d;
  logic               ovf_set;
  logic [7:0]         cnt_q, cnt_d;

  function automatic logic [B_BIT-1:0] bit_rev(input logic [B_BIT-1:0] v);
    logic [B_BIT-1:0] r;
    for (int i = 0; i < B_BIT; i++) begin
      r[i] = v[B_BIT-1-i];
    end
    return r;
  endfunction

  function automatic logic [BANKS-1:0] bank_sel(input logic [B_BIT-1:0] b);
    logic [BANKS-1:0] one;
    one = {{(BANKS-1){1'b0}}, 1'b1};
    return one << b;
  endfunction

  assign oREADY     = (state_q == S_FILL);
  assign oBUSY      = (state_q != S_IDLE);
  assign oDATA      = data_q;
  assign oADDR_WR   = addr_q;
  assign oWE        = we_q;
  assign oSTART     = start_q;
  assign oOVF       = ovf_q;
  assign oFRAME_CNT = cnt_q;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    gap_d   = gap_q;
    data_d  = data_q;
    addr_d  = addr_q;
    we_d    = '0;
    cnt_d   = cnt_q;
    start_d = (state_q == S_START);
    // Samples lost while continuous streaming cannot be accepted; set beats clear.
    ovf_set = iVALID && !oREADY && iMODE && (state_q != S_IDLE);
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (iCLR_OVF) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    case (state_q)
      S_IDLE: begin
        if (iARM || iMODE) begin
          state_d = S_FILL;
          n_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (iVALID) begin
          data_d = {iDATA[D_BIT-2], iDATA};
          addr_d = n_q[A_BIT-1:0];
          we_d   = bank_sel(bit_rev(n_q[N_BIT-1:A_BIT]));
          n_d    = n_q + N_BIT'(1);
          if (n_q == N_LAST) begin
            state_d = (GAP == 0) ? S_START : S_SETTLE;
            gap_d   = 4'd0;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_FILL;
        end
      end
      S_SETTLE: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_START;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      S_START: begin
        state_d = S_WAIT_LO;
      end
      // RDY must be seen low first so a level left over from the last frame is ignored.
      S_WAIT_LO: begin
        if (!iFHT_RDY) begin
          state_d = S_WAIT_HI;
        end else begin
          state_d = S_WAIT_LO;
        end
      end
      S_WAIT_HI: begin
        if (iFHT_RDY) begin
          cnt_d   = cnt_q + 8'd1;
          n_d     = '0;
          state_d = iMODE ? S_FILL : S_IDLE;
        end else begin
          state_d = S_WAIT_HI;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      gap_q   <= 4'd0;
      data_q  <= '0;
      addr_q  <= '0;
      we_q    <= '0;
      start_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      start_q <= start_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fht_frame_loader.sv
// Self-checking bench for fht_frame_loader: directed frames plus a random soak,
// every cycle compared against a counter-based frame model.
module tb_fht_frame_loader;

  localparam int D_BIT = 16;
  localparam int A_BIT = 8;
  localparam int BANKS = 4;
  localparam int GAP   = 2;
  localparam int BS    = 1 << A_BIT;
  localparam int N     = BANKS * BS;
  localparam int BB    = 2;

  logic clk = 1'b0;
  logic rst, mode, arm, valid, rdy, clr;
  logic [D_BIT-2:0] data;
  logic             o_ready, o_start, o_busy, o_ovf;
  logic [D_BIT-1:0] o_data;
  logic [A_BIT-1:0] o_addr;
  logic [BANKS-1:0] o_we;
  logic [7:0]       o_cnt;

  always #5 clk = ~clk;

  fht_frame_loader #(.D_BIT(D_BIT), .A_BIT(A_BIT), .BANKS(BANKS), .GAP(GAP)) dut (
    .iCLK(clk), .iRESET(rst), .iMODE(mode), .iARM(arm), .iVALID(valid),
    .iDATA(data), .iFHT_RDY(rdy), .iCLR_OVF(clr),
    .oREADY(o_ready), .oDATA(o_data), .oADDR_WR(o_addr), .oWE(o_we),
    .oSTART(o_start), .oBUSY(o_busy), .oOVF(o_ovf), .oFRAME_CNT(o_cnt)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int ncyc = 0;
  int last_wr = -100;
  bit chk_en = 1'b0;
  bit ramp_chk = 1'b0;

  // model: m_acc = -1 idle, 0..N-1 samples taken so far, N = frame full
  int m_acc = -1;
  int m_post = 0;
  bit m_lo = 1'b0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;
  logic [15:0] m_data = 16'd0;
  int m_addr = 0;
  int m_we = 0;
  bit m_start = 1'b0;
  int m_wn = -1;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, ncyc);
    end
  endtask

  function automatic int rev_bank(input int b);
    int r = 0;
    for (int i = 0; i < BB; i++) begin
      if (((b >> i) & 1) == 1) r = r | (1 << (BB - 1 - i));
    end
    return r;
  endfunction

  task automatic model_step();
    bit filling = (m_acc >= 0) && (m_acc < N);
    bit active  = (m_acc >= 0);
    int v;
    m_we = 0;
    m_start = 1'b0;
    m_wn = -1;
    if (rst) begin
      m_acc = -1; m_post = 0; m_lo = 1'b0; m_cnt = 0; m_ovf = 1'b0;
      m_data = 16'd0; m_addr = 0;
    end else begin
      if (valid && !filling && mode && active) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (m_acc < 0) begin
        if (arm || mode) m_acc = 0;
      end else if (m_acc < N) begin
        if (valid) begin
          v = int'(data);
          if (v >= 16384) v = v - 32768;
          m_data = v[15:0];
          m_addr = m_acc % BS;
          m_we   = 1 << rev_bank(m_acc / BS);
          m_wn   = m_acc;
          m_acc  = m_acc + 1;
          m_post = 0;
        end
      end else if (m_post < GAP + 1) begin
        m_post = m_post + 1;
        if (m_post == GAP + 1) m_start = 1'b1;
      end else if (!m_lo) begin
        if (!rdy) m_lo = 1'b1;
      end else if (rdy) begin
        m_cnt = (m_cnt + 1) % 256;
        m_lo  = 1'b0;
        m_acc = mode ? 0 : -1;
      end
    end
  endtask

  task automatic compare_all();
    bit e_ready = (m_acc >= 0) && (m_acc < N);
    bit e_busy  = (m_acc >= 0);
    chk_eq("ready", 32'(o_ready), 32'(e_ready));
    chk_eq("busy",  32'(o_busy),  32'(e_busy));
    chk_eq("we",    32'(o_we),    32'(m_we));
    chk_eq("start", 32'(o_start), 32'(m_start));
    chk_eq("ovf",   32'(o_ovf),   32'(m_ovf));
    chk_eq("cnt",   32'(o_cnt),   32'(m_cnt));
    if (m_we != 0) begin
      chk_eq("data", 32'(o_data), 32'(m_data));
      chk_eq("addr", 32'(o_addr), 32'(m_addr));
    end
    if (m_wn == 0) begin
      chk_eq("first_we",   32'(o_we),   32'd1);
      chk_eq("first_addr", 32'(o_addr), 32'd0);
    end
    if (ramp_chk) begin
      case (m_wn)
        256:  begin chk_eq("ramp256_we", 32'(o_we), 32'h4); chk_eq("ramp256_addr", 32'(o_addr), 32'd0); end
        512:  chk_eq("ramp512_we", 32'(o_we), 32'h2);
        1023: begin
          chk_eq("ramp1023_we", 32'(o_we), 32'h8);
          chk_eq("ramp1023_addr", 32'(o_addr), 32'd255);
          last_wr = ncyc;
        end
        default: ;
      endcase
      if (o_start) chk_eq("start_gap", 32'(ncyc - last_wr), 32'd3);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    ncyc++;
    if (chk_en) compare_all();
  endtask

  task automatic feed_until_start(input string tag, input int bound, input int vpct);
    int k = 0;
    while (!o_start && k < bound) begin
      valid = ($urandom_range(0, 99) < vpct);
      data  = 15'($urandom);
      cyc();
      k++;
    end
    chk_eq(tag, 32'(o_start), 32'd1);
  endtask

  task automatic finish_frame();
    rdy = 1'b0; cyc(); cyc();
    rdy = 1'b1; cyc(); cyc();
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; arm = 1'b0; valid = 1'b0; rdy = 1'b0; clr = 1'b0; data = '0;
    // reset held two cycles under random inputs
    mode = 1'($urandom); arm = 1'($urandom); valid = 1'($urandom);
    rdy = 1'($urandom); clr = 1'($urandom); data = 15'($urandom);
    cyc();
    chk_en = 1'b1;
    mode = 1'($urandom); arm = 1'($urandom); valid = 1'($urandom);
    rdy = 1'($urandom); clr = 1'($urandom); data = 15'($urandom);
    cyc();
    chk_eq("rst_data", 32'(o_data), 32'd0);
    chk_eq("rst_addr", 32'(o_addr), 32'd0);
    chk_eq("rst_busy", 32'(o_busy), 32'd0);
    rst = 1'b0; mode = 1'b0; arm = 1'b0; valid = 1'b0; rdy = 1'b1; clr = 1'b0;

    // single-shot ramp
    ramp_chk = 1'b1;
    arm = 1'b1; cyc(); arm = 1'b0;
    valid = 1'b1;
    for (int n = 0; n < N; n++) begin
      data = 15'(n);
      cyc();
    end
    valid = 1'b0;
    for (int k = 0; k < 20 && !o_start; k++) cyc();
    chk_eq("ramp_start", 32'(o_start), 32'd1);
    finish_frame();
    chk_eq("ramp_cnt",  32'(o_cnt),  32'd1);
    chk_eq("ramp_idle", 32'(o_busy), 32'd0);
    ramp_chk = 1'b0;

    // sign extension, then a frame that sees a stale high RDY
    rdy = 1'b1;
    arm = 1'b1; cyc(); arm = 1'b0;
    valid = 1'b1; data = 15'h4000; cyc();
    chk_eq("sext_neg", 32'(o_data), 32'h0000C000);
    data = 15'h3FFF; cyc();
    chk_eq("sext_pos", 32'(o_data), 32'h00003FFF);
    feed_until_start("stale_start", 6000, 75);
    valid = 1'b0;
    repeat (20) cyc();
    chk_eq("stale_cnt",  32'(o_cnt),  32'd1);
    chk_eq("stale_busy", 32'(o_busy), 32'd1);
    rdy = 1'b0; cyc();
    rdy = 1'b1; cyc(); cyc();
    chk_eq("stale_done_cnt",  32'(o_cnt),  32'd2);
    chk_eq("stale_done_busy", 32'(o_busy), 32'd0);

    // continuous mode with overflow, then mode dropped mid-frame
    mode = 1'b1; rdy = 1'b1;
    feed_until_start("cont_start", 1200, 100);
    chk_eq("cont_ovf", 32'(o_ovf), 32'd1);
    cyc();
    chk_eq("cont_ovf_wait", 32'(o_ovf), 32'd1);
    rdy = 1'b0; cyc();
    rdy = 1'b1; cyc();
    chk_eq("cont_refill", 32'(o_ready), 32'd1);
    clr = 1'b1; data = 15'($urandom); cyc(); clr = 1'b0;
    chk_eq("clr_ovf", 32'(o_ovf), 32'd0);
    repeat (100) begin data = 15'($urandom); cyc(); end
    mode = 1'b0;
    feed_until_start("mode0_start", 1200, 100);
    valid = 1'b0;
    finish_frame();
    chk_eq("mode0_idle", 32'(o_busy), 32'd0);
    chk_eq("mode0_ovf",  32'(o_ovf),  32'd0);

    // reset in the middle of a fill
    arm = 1'b1; cyc(); arm = 1'b0;
    valid = 1'b1;
    repeat (300) begin data = 15'($urandom); cyc(); end
    rst = 1'b1; cyc(); rst = 1'b0; valid = 1'b0;
    chk_eq("midrst_busy", 32'(o_busy), 32'd0);
    chk_eq("midrst_addr", 32'(o_addr), 32'd0);
    repeat (10) cyc();
    arm = 1'b1; cyc(); arm = 1'b0;
    feed_until_start("midrst_start", 2000, 80);
    valid = 1'b0;
    finish_frame();

    // random soak
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 299) == 0) mode = ~mode;
      arm   = ($urandom_range(0, 19) == 0);
      valid = ($urandom_range(0, 99) < 80);
      data  = 15'($urandom);
      rdy   = 1'($urandom);
      clr   = ($urandom_range(0, 49) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
